// File: rtl/async_stage_pkg.sv
// Shared types and helpers for the async crossing stage: arbiter state,
// round-robin search and tag extraction for read-side consumers.
package async_stage_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int MAX_NREQ  = 16;
   localparam int MAX_IDW   = 4;
   localparam int POSW      = MAX_IDW + 1;
   localparam int MAX_WDATA = 128;

   typedef struct packed {
      logic               found;
      logic [MAX_IDW-1:0] idx;
   } rr_pick_t;

   // First set bit at or above ptr, wrapping at nreq; ptr is assumed < nreq.
   function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                        input logic [MAX_IDW-1:0]  ptr,
                                        input int                  nreq);
      rr_pick_t       res;
      logic [POSW-1:0] pos;
      res = '0;
      for (int k = 0; k < MAX_NREQ; k++) begin
         pos = {1'b0, ptr} + POSW'(k);
         if (pos >= POSW'(nreq)) pos = pos - POSW'(nreq);
         if (k < nreq && !res.found && valid[pos[MAX_IDW-1:0]]) begin
            res.found = 1'b1;
            res.idx   = pos[MAX_IDW-1:0];
         end
      end
      return res;
   endfunction

   function automatic logic [MAX_IDW-1:0] tag_of(input logic [MAX_WDATA-1:0] wdata,
                                                 input int                   dwid,
                                                 input int                   idw);
      logic [MAX_WDATA-1:0] sh;
      logic [MAX_IDW-1:0]   mask;
      sh   = wdata >> dwid;
      mask = '0;
      for (int b = 0; b < MAX_IDW; b++) begin
         if (b < idw) mask[b] = 1'b1;
      end
      return sh[MAX_IDW-1:0] & mask;
   endfunction

endpackage

// File: rtl/async_stage_wr_arb_rr_picker.sv
// Combinational round-robin search: first valid requester from ptr upward,
// wrapping at NREQ-1.
module rr_picker
   import async_stage_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  idx,
   output logic            found
);

   rr_pick_t pick;

   always_comb begin
      pick = rr_pick(MAX_NREQ'(valid), MAX_IDW'(ptr), NREQ);
   end

   assign idx   = IDW'(pick.idx);
   assign found = pick.found;

endmodule

// File: rtl/async_stage_wr_arb.sv
// Round-robin write-side arbiter sharing one crossing stage's write port;
// each beat is tagged with its requester index.
//
// state | meaning
// IDLE  | no grant held; candidate is round-robin pick from rr_ptr
// BURST | owner holds the grant until last beat or MAXBURST cap
module async_stage_wr_arb
   import async_stage_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DWID     = 32,
   parameter int MAXBURST = 8,
   parameter int IDW      = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_last,
   input  logic [NREQ*DWID-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 stage_writex,
   output logic [DWID+IDW-1:0]  stage_wdata,
   input  logic                 stage_wfull,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy
);

   localparam int             CW      = $clog2(MAXBURST + 1);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
   localparam logic [CW-1:0]  CAP     = CW'(MAXBURST);

   arb_state_e      state, state_nxt;
   logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
   logic [IDW-1:0]  owner, owner_nxt;
   logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
   logic [IDW-1:0]  pick_idx;
   logic            pick_found;
   logic [IDW-1:0]  cand;
   logic            cand_ok;
   logic            accept;
   logic            burst_end;
   logic [DWID-1:0] data_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*DWID +: DWID];
   end

   rr_picker #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_picker (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      cand    = pick_idx;
      cand_ok = pick_found;
      if (state == BURST) begin
         cand    = owner;
         cand_ok = 1'b1;
      end
   end

   assign accept    = cand_ok && req_valid[cand] && !stage_wfull && !rst;
   assign burst_end = req_last[cand] || (beat_cnt + CW'(1) == CAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      owner_nxt    = owner;
      beat_cnt_nxt = beat_cnt;
      if (accept) begin
         if (burst_end) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = (cand == LAST_ID) ? '0 : cand + IDW'(1);
            beat_cnt_nxt = '0;
         end else begin
            state_nxt    = BURST;
            owner_nxt    = cand;
            beat_cnt_nxt = beat_cnt + CW'(1);
         end
      end
   end

   // Reset forces every handshake output low so no beat is lost mid-reset.
   always_comb begin
      req_ready    = '0;
      stage_writex = 1'b0;
      busy         = 1'b0;
      grant_id     = '0;
      stage_wdata  = {cand, data_arr[cand]};
      if (!rst) begin
         grant_id     = cand;
         busy         = (state == BURST);
         stage_writex = accept;
         if (cand_ok && !stage_wfull) req_ready[cand] = 1'b1;
      end
   end

endmodule

// File: tb/tb_async_stage_wr_arb.sv
// Bench for async_stage_wr_arb: per-requester beat queues, a round-robin
// reference model and a one-cycle-full stage model; NREQ=4 and NREQ=3 instances.
module tb_async_stage_wr_arb;

   localparam int DW = 32;
   localparam int MB = 8;

   logic clk;
   logic rst;
   logic [3:0]    v [2];
   logic [3:0]    l [2];
   logic [DW-1:0] pay [2][4];
   logic          wf [2];
   logic [4*DW-1:0] d4;
   logic [3*DW-1:0] d3;

   logic [3:0]    rdy4;
   logic [2:0]    rdy3;
   logic          wx4, wx3, busy4, busy3;
   logic [1:0]    gid4, gid3;
   logic [DW+1:0] wd4, wd3;

   assign d4 = {pay[0][3], pay[0][2], pay[0][1], pay[0][0]};
   assign d3 = {pay[1][2], pay[1][1], pay[1][0]};

   async_stage_wr_arb #(.NREQ(4), .DWID(DW), .MAXBURST(MB)) dut4 (
      .clk(clk), .rst(rst), .req_valid(v[0]), .req_last(l[0]), .req_data(d4),
      .req_ready(rdy4), .stage_writex(wx4), .stage_wdata(wd4),
      .stage_wfull(wf[0]), .grant_id(gid4), .busy(busy4)
   );

   async_stage_wr_arb #(.NREQ(3), .DWID(DW), .MAXBURST(MB)) dut3 (
      .clk(clk), .rst(rst), .req_valid(v[1][2:0]), .req_last(l[1][2:0]), .req_data(d3),
      .req_ready(rdy3), .stage_writex(wx3), .stage_wdata(wd3),
      .stage_wfull(wf[1]), .grant_id(gid3), .busy(busy3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // reference model state, per DUT
   bit m_burst [2];
   int m_own [2];
   int m_ptr [2];
   int m_cnt [2];

   logic [DW-1:0] q_dat [4][$];
   logic          q_last [4][$];
   logic [1:0]    acc_tag [$];
   logic [DW-1:0] acc_dat [$];
   bit            force_full;

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < 4; i++) s += q_dat[i[1:0]].size();
      return s;
   endfunction

   task automatic push_beat(input int i, input logic [DW-1:0] d, input logic last);
      q_dat[i[1:0]].push_back(d);
      q_last[i[1:0]].push_back(last);
   endtask

   task automatic drive(input bit w, input bit gaps);
      int n;
      n = w ? 3 : 4;
      v[0] = '0;
      v[1] = '0;
      l[0] = 4'($urandom);
      l[1] = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         pay[0][i[1:0]] = $urandom;
         pay[1][i[1:0]] = $urandom;
      end
      for (int i = 0; i < n; i++) begin
         if (q_dat[i[1:0]].size() > 0 && !(gaps && $urandom_range(3) == 0)) begin
            v[w][i[1:0]]   = 1'b1;
            pay[w][i[1:0]] = q_dat[i[1:0]][0];
            l[w][i[1:0]]   = q_last[i[1:0]][0];
         end
      end
   endtask

   // Check one cycle against the model, then advance the model over the edge.
   task automatic step(input bit w);
      int            n, ci;
      bit            found, e_wx, e_busy, lastb;
      logic [1:0]    cand;
      logic [3:0]    e_rdy, o_rdy;
      logic          o_wx, o_busy;
      logic [1:0]    o_gid;
      logic [DW+1:0] o_wd;
      n = w ? 3 : 4;
      @(negedge clk);
      found = 1'b0;
      ci    = 0;
      if (m_burst[w]) begin
         found = 1'b1;
         ci    = m_own[w];
      end else begin
         for (int k = 0; k < n; k++) begin
            int j;
            j = (m_ptr[w] + k) % n;
            if (!found && v[w][j[1:0]]) begin
               found = 1'b1;
               ci    = j;
            end
         end
      end
      cand   = ci[1:0];
      e_rdy  = (found && !wf[w] && !rst) ? (4'b0001 << cand) : 4'b0000;
      e_wx   = found && v[w][cand] && !wf[w] && !rst;
      e_busy = m_burst[w] && !rst;
      o_rdy  = w ? {1'b0, rdy3} : rdy4;
      o_wx   = w ? wx3 : wx4;
      o_busy = w ? busy3 : busy4;
      o_gid  = w ? gid3 : gid4;
      o_wd   = w ? wd3 : wd4;

      checks++;
      if (o_rdy !== e_rdy) begin
         errors++;
         $display("FAIL req_ready dut%0d t=%0t: got %b expected %b", n, $time, o_rdy, e_rdy);
      end
      checks++;
      if (o_wx !== e_wx) begin
         errors++;
         $display("FAIL stage_writex dut%0d t=%0t: got %b expected %b", n, $time, o_wx, e_wx);
      end
      checks++;
      if (o_busy !== e_busy) begin
         errors++;
         $display("FAIL busy dut%0d t=%0t: got %b expected %b", n, $time, o_busy, e_busy);
      end
      if (found || rst) begin
         checks++;
         if (o_gid !== (rst ? 2'd0 : cand)) begin
            errors++;
            $display("FAIL grant_id dut%0d t=%0t: got %0d expected %0d", n, $time, o_gid, rst ? 2'd0 : cand);
         end
      end
      if (e_wx) begin
         checks++;
         if (o_wd !== {cand, pay[w][cand]}) begin
            errors++;
            $display("FAIL stage_wdata dut%0d t=%0t: got %h expected %h", n, $time, o_wd, {cand, pay[w][cand]});
         end
      end
      if (o_wx === 1'b1) begin
         acc_tag.push_back(o_wd[DW+1:DW]);
         acc_dat.push_back(o_wd[DW-1:0]);
         checks++;
         if (int'(o_wd[DW+1:DW]) >= n) begin
            errors++;
            $display("FAIL tag_range dut%0d: got tag %0d, NREQ %0d", n, o_wd[DW+1:DW], n);
         end
      end

      @(posedge clk);
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            m_burst[d[0]] = 1'b0;
            m_own[d[0]]   = 0;
            m_ptr[d[0]]   = 0;
            m_cnt[d[0]]   = 0;
         end
      end else if (e_wx) begin
         lastb = l[w][cand] || (m_cnt[w] + 1 == MB);
         if (lastb) begin
            m_burst[w] = 1'b0;
            m_ptr[w]   = (ci + 1) % n;
            m_cnt[w]   = 0;
         end else begin
            m_burst[w] = 1'b1;
            m_own[w]   = ci;
            m_cnt[w]   = m_cnt[w] + 1;
         end
         void'(q_dat[cand].pop_front());
         void'(q_last[cand].pop_front());
      end
      #1;
      wf[w] = e_wx || force_full;
   endtask

   task automatic run(input bit w, input bit gaps, input bit rfull, input int budget);
      int c = 0;
      while (pending() > 0 && c < budget) begin
         if (rfull) force_full = ($urandom_range(4) == 0);
         drive(w, gaps);
         step(w);
         c++;
      end
      force_full = 1'b0;
      checks++;
      if (pending() != 0) begin
         errors++;
         $display("FAIL run_timeout: %0d beats still queued after %0d cycles", pending(), c);
      end
   endtask

   task automatic do_reset(input bit w);
      for (int i = 0; i < 4; i++) begin
         q_dat[i[1:0]].delete();
         q_last[i[1:0]].delete();
      end
      force_full = 1'b0;
      rst = 1'b1;
      drive(w, 1'b0);
      step(w);
      rst = 1'b0;
      acc_tag.delete();
      acc_dat.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) push_beat(i, 32'h100 + i, 1'b1);
      repeat (3) begin
         drive(1'b0, 1'b0);
         step(1'b0);
      end
      checks++;
      if (rdy4 !== 4'b0 || wx4 !== 1'b0 || busy4 !== 1'b0 || gid4 !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b writex=%b busy=%b grant=%0d expected all zero",
                  rdy4, wx4, busy4, gid4);
      end
      do_reset(1'b0);
   endtask

   task automatic test_alternate();
      logic [1:0] exp_seq [$];
      do_reset(1'b0);
      exp_seq = '{2'd0, 2'd2, 2'd0, 2'd2};
      for (int b = 0; b < 2; b++) begin
         push_beat(0, 32'h0A00 + b, 1'b1);
         push_beat(2, 32'h0C00 + b, 1'b1);
      end
      run(1'b0, 1'b0, 1'b0, 100);
      checks++;
      if (acc_tag.size() != exp_seq.size()) begin
         errors++;
         $display("FAIL alternate_count: got %0d grants expected %0d", acc_tag.size(), exp_seq.size());
      end else begin
         for (int i = 0; i < exp_seq.size(); i++) begin
            checks++;
            if (acc_tag[i] !== exp_seq[i]) begin
               errors++;
               $display("FAIL alternate_order[%0d]: got %0d expected %0d", i, acc_tag[i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_burst();
      logic [1:0]    exp_tag [$];
      logic [DW-1:0] exp_dat [$];
      do_reset(1'b0);
      exp_tag = '{2'd1, 2'd1, 2'd1, 2'd3};
      exp_dat = '{32'hA1, 32'hA2, 32'hA3, 32'hB0};
      push_beat(1, 32'hA1, 1'b0);
      push_beat(1, 32'hA2, 1'b0);
      push_beat(1, 32'hA3, 1'b1);
      push_beat(3, 32'hB0, 1'b1);
      run(1'b0, 1'b0, 1'b0, 100);
      checks++;
      if (acc_tag.size() != exp_tag.size()) begin
         errors++;
         $display("FAIL burst_count: got %0d beats expected %0d", acc_tag.size(), exp_tag.size());
      end else begin
         for (int i = 0; i < exp_tag.size(); i++) begin
            checks++;
            if (acc_tag[i] !== exp_tag[i] || acc_dat[i] !== exp_dat[i]) begin
               errors++;
               $display("FAIL burst_beat[%0d]: got tag %0d data %h expected tag %0d data %h",
                        i, acc_tag[i], acc_dat[i], exp_tag[i], exp_dat[i]);
            end
         end
      end
   endtask

   task automatic test_maxburst();
      do_reset(1'b0);
      for (int b = 0; b < 12; b++) push_beat(0, 32'h5000 + b, 1'b0);
      push_beat(1, 32'h6000, 1'b1);
      run(1'b0, 1'b0, 1'b0, 200);
      checks++;
      if (acc_tag.size() != 13) begin
         errors++;
         $display("FAIL maxburst_count: got %0d beats expected 13", acc_tag.size());
      end else begin
         for (int i = 0; i < 13; i++) begin
            checks++;
            if (acc_tag[i] !== ((i == 8) ? 2'd1 : 2'd0)) begin
               errors++;
               $display("FAIL maxburst_order[%0d]: got %0d expected %0d", i, acc_tag[i], (i == 8) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_wfull();
      int         n0;
      logic [1:0] exp_seq [$];
      do_reset(1'b0);
      exp_seq = '{2'd2, 2'd3, 2'd0, 2'd1};
      push_beat(1, 32'h77, 1'b1);
      run(1'b0, 1'b0, 1'b0, 50);
      for (int i = 0; i < 4; i++) push_beat(i, 32'h800 + i, 1'b1);
      n0 = acc_tag.size();
      force_full = 1'b1;
      repeat (5) begin
         drive(1'b0, 1'b0);
         step(1'b0);
      end
      force_full = 1'b0;
      checks++;
      if (acc_tag.size() != n0) begin
         errors++;
         $display("FAIL wfull_hold: got %0d writes while full expected 0", acc_tag.size() - n0);
      end
      run(1'b0, 1'b0, 1'b0, 100);
      checks++;
      if (acc_tag.size() != n0 + 4) begin
         errors++;
         $display("FAIL wfull_release_count: got %0d grants expected 4", acc_tag.size() - n0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_tag[n0+i] !== exp_seq[i]) begin
               errors++;
               $display("FAIL wfull_release_order[%0d]: got %0d expected %0d", i, acc_tag[n0+i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midburst();
      int c = 0;
      do_reset(1'b0);
      push_beat(2, 32'hC1, 1'b0);
      push_beat(2, 32'hC2, 1'b0);
      push_beat(2, 32'hC3, 1'b1);
      while (acc_tag.size() == 0 && c < 20) begin
         drive(1'b0, 1'b0);
         step(1'b0);
         c++;
      end
      rst = 1'b1;
      drive(1'b0, 1'b0);
      step(1'b0);
      rst = 1'b0;
      checks++;
      if (busy4 !== 1'b0) begin
         errors++;
         $display("FAIL midburst_reset_busy: got %b expected 0", busy4);
      end
      push_beat(1, 32'hD1, 1'b1);
      run(1'b0, 1'b0, 1'b0, 100);
      checks++;
      if (acc_tag.size() != 4 || acc_tag[0] !== 2'd2 || acc_tag[1] !== 2'd1) begin
         errors++;
         $display("FAIL midburst_regrant: got %0d grants, first two %0d,%0d expected 4 grants 2,1",
                  acc_tag.size(), acc_tag.size() > 0 ? acc_tag[0] : 2'd0,
                  acc_tag.size() > 1 ? acc_tag[1] : 2'd0);
      end
   endtask

   task automatic test_nreq3();
      logic [1:0] exp_seq [$];
      do_reset(1'b1);
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd0};
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 3; i++) push_beat(i, 32'h3000 + 16 * b + i, 1'b1);
      end
      run(1'b1, 1'b0, 1'b0, 100);
      checks++;
      if (acc_tag.size() != 6) begin
         errors++;
         $display("FAIL nreq3_count: got %0d grants expected 6", acc_tag.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_tag[i] !== exp_seq[i]) begin
               errors++;
               $display("FAIL nreq3_order[%0d]: got %0d expected %0d", i, acc_tag[i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         bit w;
         int n;
         w = r[0];
         n = w ? 3 : 4;
         do_reset(w);
         for (int i = 0; i < n; i++) begin
            int nb;
            nb = $urandom_range(12);
            for (int b = 0; b < nb; b++) begin
               push_beat(i, $urandom, (b == nb - 1) || ($urandom_range(3) == 0));
            end
         end
         run(w, 1'b1, 1'b1, 2000);
      end
   endtask

   initial begin
      rst        = 1'b1;
      force_full = 1'b0;
      wf[0]      = 1'b0;
      wf[1]      = 1'b0;
      v[0]       = '0;
      v[1]       = '0;
      l[0]       = '0;
      l[1]       = '0;
      for (int i = 0; i < 4; i++) begin
         pay[0][i[1:0]] = '0;
         pay[1][i[1:0]] = '0;
      end
      for (int d = 0; d < 2; d++) begin
         m_burst[d[0]] = 1'b0;
         m_own[d[0]]   = 0;
         m_ptr[d[0]]   = 0;
         m_cnt[d[0]]   = 0;
      end
      test_reset();
      test_alternate();
      test_burst();
      test_maxburst();
      test_wfull();
      test_reset_midburst();
      test_nreq3();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
